// File: rtl/cmd_sched.sv
// cmd_sched: arbitrates queued UART commands and tour moves onto a single cmd_proc
// handshake, with tour/UART fairness and a response watchdog.
module cmd_sched #(
  parameter int unsigned DEPTH   = 4,
  parameter logic [23:0] TMO_CYC = 24'd5_000_000,
  parameter int unsigned FAIR_N  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] uart_cmd,
  input  logic        uart_cmd_rdy,
  output logic        uart_clr,
  input  logic [15:0] tour_cmd,
  input  logic        tour_vld,
  input  logic        tour_last,
  output logic        tour_ack,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [7:0]  resp,
  output logic        resp_vld,
  output logic        tmo_err,
  output logic        busy
);

  localparam int unsigned CMD_W  = 16;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned FAIR_W = $clog2(FAIR_N + 1);
  localparam int unsigned TMO_W  = 24;

  typedef enum logic [1:0] {IDLE, ISSUE, EXEC, RESP} state_t;

  state_t            state_q, state_d;
  logic [CMD_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [FAIR_W-1:0] fair_q, fair_d;
  logic [TMO_W-1:0]  wd_q, wd_d;
  logic              src_tour_q, src_tour_d;
  logic              last_q, last_d;
  logic [CMD_W-1:0]  cmd_d;
  logic              cmd_rdy_d, tour_ack_d, resp_vld_d, tmo_err_d;
  logic [7:0]        resp_d;
  logic              fifo_empty_c, fifo_full_c, push_c, pop_c;

  assign fifo_empty_c = (count_q == '0);
  assign fifo_full_c  = (count_q == CNT_W'(DEPTH));
  // The previous capture's uart_clr is still visible, so the same entry is never taken twice.
  assign push_c       = uart_cmd_rdy && !fifo_full_c && !uart_clr;

  // Next-state, arbitration and output decode.
  always_comb begin
    state_d    = state_q;
    fair_d     = fair_q;
    wd_d       = wd_q;
    src_tour_d = src_tour_q;
    last_d     = last_q;
    cmd_d      = cmd;
    cmd_rdy_d  = cmd_rdy;
    tour_ack_d = 1'b0;
    resp_d     = resp;
    resp_vld_d = 1'b0;
    tmo_err_d  = tmo_err;
    pop_c      = 1'b0;
    case (state_q)
      IDLE: begin
        if (fifo_empty_c) fair_d = '0;
        if (tour_vld && (fifo_empty_c || fair_q < FAIR_W'(FAIR_N))) begin
          state_d    = ISSUE;
          cmd_d      = tour_cmd;
          cmd_rdy_d  = 1'b1;
          src_tour_d = 1'b1;
          last_d     = tour_last;
          if (!fifo_empty_c) fair_d = fair_q + FAIR_W'(1);
        end else if (!fifo_empty_c) begin
          state_d    = ISSUE;
          cmd_d      = mem[rd_ptr_q];
          cmd_rdy_d  = 1'b1;
          src_tour_d = 1'b0;
          last_d     = 1'b0;
          pop_c      = 1'b1;
          fair_d     = '0;
        end
      end
      ISSUE: begin
        if (clr_cmd_rdy) begin
          state_d    = EXEC;
          cmd_rdy_d  = 1'b0;
          tour_ack_d = src_tour_q;
          wd_d       = '0;
        end
      end
      EXEC: begin
        // A response arriving on the timeout cycle still wins.
        if (send_resp) begin
          state_d    = RESP;
          resp_vld_d = 1'b1;
          resp_d     = (!src_tour_q || last_q) ? 8'hA5 : 8'h5A;
        end else if (wd_q == TMO_CYC - 24'd1) begin
          state_d   = IDLE;
          tmo_err_d = 1'b1;
        end else begin
          wd_d = wd_q + TMO_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FIFO storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr_q] <= uart_cmd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      fair_q     <= '0;
      wd_q       <= '0;
      src_tour_q <= 1'b0;
      last_q     <= 1'b0;
      cmd        <= 16'h0000;
      cmd_rdy    <= 1'b0;
      uart_clr   <= 1'b0;
      tour_ack   <= 1'b0;
      resp       <= 8'h00;
      resp_vld   <= 1'b0;
      tmo_err    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      fair_q     <= fair_d;
      wd_q       <= wd_d;
      src_tour_q <= src_tour_d;
      last_q     <= last_d;
      cmd        <= cmd_d;
      cmd_rdy    <= cmd_rdy_d;
      uart_clr   <= push_c;
      tour_ack   <= tour_ack_d;
      resp       <= resp_d;
      resp_vld   <= resp_vld_d;
      tmo_err    <= tmo_err_d;
      busy       <= (state_d != IDLE);
      if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_c, pop_c})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_sched.sv
// Bench for cmd_sched: queue-based reference model compared every cycle, plus directed scenarios.
module tb_cmd_sched;
  localparam int DEPTH  = 4;
  localparam int FAIR_N = 4;
  localparam int TMO    = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] uart_cmd;
  logic        uart_cmd_rdy;
  logic        uart_clr;
  logic [15:0] tour_cmd;
  logic        tour_vld;
  logic        tour_last;
  logic        tour_ack;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [7:0]  resp;
  logic        resp_vld;
  logic        tmo_err;
  logic        busy;

  always #5 clk = ~clk;

  cmd_sched #(.DEPTH(DEPTH), .TMO_CYC(24'(TMO)), .FAIR_N(FAIR_N)) dut (
    .clk(clk), .rst(rst), .uart_cmd(uart_cmd), .uart_cmd_rdy(uart_cmd_rdy), .uart_clr(uart_clr),
    .tour_cmd(tour_cmd), .tour_vld(tour_vld), .tour_last(tour_last), .tour_ack(tour_ack),
    .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp),
    .resp(resp), .resp_vld(resp_vld), .tmo_err(tmo_err), .busy(busy)
  );

  int n_chk = 0, n_pass = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endfunction

  // Reference model: FIFO as a queue, command lifecycle as a phase number.
  logic [15:0] mq[$];
  int          m_phase = 0, m_age = 0, m_fair = 0;
  bit          m_src = 0, m_last = 0;
  logic        m_clr = 0, m_ack = 0, m_cmd_rdy = 0, m_resp_vld = 0, m_tmo = 0, m_busy = 0;
  logic [15:0] m_cmd = '0;
  logic [7:0]  m_resp = '0;
  bit          chk_en = 0;

  task automatic model_step();
    bit push, empty;
    if (rst) begin
      mq.delete();
      m_phase = 0; m_age = 0; m_fair = 0; m_src = 0; m_last = 0;
      m_clr = 0; m_ack = 0; m_cmd = '0; m_cmd_rdy = 0; m_resp = '0; m_resp_vld = 0; m_tmo = 0; m_busy = 0;
      return;
    end
    push  = uart_cmd_rdy && (mq.size() < DEPTH) && !m_clr;
    empty = (mq.size() == 0);
    m_ack = 0;
    m_resp_vld = 0;
    case (m_phase)
      0: begin
        if (empty) m_fair = 0;
        if (tour_vld && (empty || m_fair < FAIR_N)) begin
          if (!empty) m_fair = (m_fair + 1 > FAIR_N) ? FAIR_N : m_fair + 1;
          m_cmd = tour_cmd; m_src = 1; m_last = tour_last; m_phase = 1; m_cmd_rdy = 1;
        end else if (!empty) begin
          m_cmd = mq.pop_front(); m_src = 0; m_last = 0; m_fair = 0; m_phase = 1; m_cmd_rdy = 1;
        end
      end
      1: if (clr_cmd_rdy) begin m_phase = 2; m_cmd_rdy = 0; m_ack = m_src; m_age = 0; end
      2: begin
        if (send_resp) begin
          m_phase = 3; m_resp_vld = 1; m_resp = (!m_src || m_last) ? 8'hA5 : 8'h5A;
        end else if (m_age == TMO - 1) begin
          m_phase = 0; m_tmo = 1;
        end else m_age++;
      end
      default: m_phase = 0;
    endcase
    if (push) mq.push_back(uart_cmd);
    m_clr  = push;
    m_busy = (m_phase != 0);
  endtask

  // Environment agents (UART wrapper, tour sequencer, cmd_proc), reacting to the model.
  logic [15:0] uq[$];
  logic [16:0] tq[$];
  bit clr_seen = 0, spurious = 0;
  int prev_phase = 0, wait_c = 0, wait_r = 0, fix_clr = -1, fix_resp = -1;

  task automatic agents();
    if (clr_seen && uq.size() > 0) uq.delete(0);
    clr_seen = m_clr;
    uart_cmd_rdy = (uq.size() > 0);
    uart_cmd     = (uq.size() > 0) ? uq[0] : 16'h0;
    if (m_ack && tq.size() > 0) tq.delete(0);
    tour_vld  = (tq.size() > 0);
    tour_cmd  = (tq.size() > 0) ? tq[0][15:0] : 16'h0;
    tour_last = (tq.size() > 0) ? tq[0][16] : 1'b0;
    if (m_phase != prev_phase) begin
      if (m_phase == 1) wait_c = (fix_clr >= 0) ? fix_clr : int'($urandom_range(0, 3));
      if (m_phase == 2) wait_r = (fix_resp >= 0) ? fix_resp :
                                 (($urandom_range(0, 9) == 0) ? 40 : int'($urandom_range(0, 6)));
    end
    prev_phase  = m_phase;
    clr_cmd_rdy = 0;
    send_resp   = 0;
    if (m_phase == 1) begin if (wait_c == 0) clr_cmd_rdy = 1; else wait_c--; end
    if (m_phase == 2) begin if (wait_r == 0) send_resp = 1; else wait_r--; end
    if (spurious) begin
      if (m_phase != 1 && $urandom_range(0, 7) == 0) clr_cmd_rdy = 1;
      if (m_phase != 2 && $urandom_range(0, 7) == 0) send_resp = 1;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    if (rst) chk_en = 1;
    #1;
    agents();
  endtask

  // Compare process and DUT event monitor.
  int cyc = 0, n_clr = 0, n_ack = 0, fall_cyc = 0, tmo_cyc = 0;
  logic rdy_prev = 0, tmo_prev = 0;
  logic [15:0] cmd_log[$];
  logic [7:0]  resp_log[$];

  always @(negedge clk) begin
    cyc++;
    if (chk_en) begin
      check("outputs", 64'({uart_clr, tour_ack, cmd, cmd_rdy, resp, resp_vld, tmo_err, busy}),
            64'({m_clr, m_ack, m_cmd, m_cmd_rdy, m_resp, m_resp_vld, m_tmo, m_busy}));
      if (uart_clr === 1'b1) n_clr++;
      if (tour_ack === 1'b1) n_ack++;
      if (resp_vld === 1'b1) resp_log.push_back(resp);
      if (cmd_rdy === 1'b1 && rdy_prev !== 1'b1) cmd_log.push_back(cmd);
      if (rdy_prev === 1'b1 && cmd_rdy === 1'b0) fall_cyc = cyc;
      if (tmo_err === 1'b1 && tmo_prev !== 1'b1) tmo_cyc = cyc;
      rdy_prev = cmd_rdy;
      tmo_prev = tmo_err;
    end
  end

  function automatic logic [15:0] cmd_at(int i);
    if (i < cmd_log.size()) return cmd_log[i];
    return 'x;
  endfunction

  function automatic logic [7:0] resp_at(int i);
    if (i < resp_log.size()) return resp_log[i];
    return 'x;
  endfunction

  task automatic run_resp(int n, int budget, string name);
    for (int i = 0; i < budget && resp_log.size() < n; i++) cycle();
    check(name, 64'(resp_log.size()), 64'(n));
  endtask

  int b_clr, b_ack, b_resp, b_cmd, cnt, tries;
  logic [9:0] seq;

  initial begin
    rst = 1; uart_cmd = '0; uart_cmd_rdy = 0; tour_cmd = '0; tour_vld = 0; tour_last = 0;
    clr_cmd_rdy = 0; send_resp = 0;
    repeat (3) cycle();
    check("reset_outputs", 64'({uart_clr, tour_ack, cmd, cmd_rdy, resp, resp_vld, tmo_err, busy}), 64'(0));
    rst = 0;

    // Single UART command, cmd_proc takes it 2 cycles late, responds 5 cycles later.
    fix_clr = 2; fix_resp = 5;
    b_clr = n_clr; b_resp = resp_log.size(); b_cmd = cmd_log.size();
    uq.push_back(16'h2002);
    run_resp(b_resp + 1, 60, "uart_done");
    repeat (3) cycle();
    check("uart_clr_count", 64'(n_clr - b_clr), 64'(1));
    check("uart_cmd", 64'(cmd_at(b_cmd)), 64'(16'h2002));
    check("uart_resp", 64'(resp_at(b_resp)), 64'(8'hA5));

    // 24-move tour, last flag on the final move.
    fix_clr = 0; fix_resp = 1;
    b_ack = n_ack; b_resp = resp_log.size();
    for (int i = 0; i < 24; i++) tq.push_back({(i == 23), 16'h1000 + 16'(i)});
    run_resp(b_resp + 24, 480, "tour_done");
    check("tour_acks", 64'(n_ack - b_ack), 64'(24));
    cnt = 0;
    for (int i = 0; i < 23; i++) if (resp_at(b_resp + i) == 8'h5A) cnt++;
    check("tour_5a_count", 64'(cnt), 64'(23));
    check("tour_last_resp", 64'(resp_at(b_resp + 23)), 64'(8'hA5));

    // Fairness: warm-up UART grant, then continuous tour with two UART commands queued.
    fix_clr = 3; fix_resp = 3;
    b_cmd = cmd_log.size(); b_resp = resp_log.size();
    uq.push_back(16'hB000);
    tries = 0;
    while (cmd_log.size() <= b_cmd && tries < 20) begin cycle(); tries++; end
    uq.push_back(16'hB001); uq.push_back(16'hB002);
    for (int i = 0; i < 12; i++) tq.push_back({(i == 11), 16'h1100 + 16'(i)});
    run_resp(b_resp + 15, 300, "fair_done");
    for (int i = 0; i < 10; i++) seq[9 - i] = (cmd_at(b_cmd + 1 + i) >> 12) == 16'h1;
    check("fair_order", 64'(seq), 64'(10'b1111011110));

    // FIFO full: a stalled tour move blocks while five UART commands arrive.
    fix_clr = 60; fix_resp = 0;
    b_clr = n_clr; b_cmd = cmd_log.size(); b_resp = resp_log.size();
    tq.push_back({1'b1, 16'h1F00});
    repeat (3) cycle();
    fix_clr = 0;
    for (int i = 0; i < 5; i++) uq.push_back(16'hC000 + 16'(i));
    repeat (25) cycle();
    check("full_clr_count", 64'(n_clr - b_clr), 64'(4));
    run_resp(b_resp + 6, 200, "full_done");
    check("full_clr_total", 64'(n_clr - b_clr), 64'(5));
    for (int i = 0; i < 5; i++) check("full_order", 64'(cmd_at(b_cmd + 1 + i)), 64'(16'hC000 + 16'(i)));

    // Watchdog timeout, then a normal command, then reset clears the sticky error.
    fix_clr = 0; fix_resp = 1000;
    b_resp = resp_log.size();
    uq.push_back(16'hD000);
    repeat (40) cycle();
    check("tmo_set", 64'(tmo_err), 64'(1));
    check("tmo_latency", 64'(tmo_cyc - fall_cyc), 64'(16));
    check("tmo_no_resp", 64'(resp_log.size() - b_resp), 64'(0));
    check("tmo_idle", 64'(busy), 64'(0));
    fix_resp = 2;
    uq.push_back(16'hD001);
    run_resp(b_resp + 1, 60, "tmo_next_done");
    check("tmo_next_resp", 64'(resp_at(b_resp)), 64'(8'hA5));
    check("tmo_sticky", 64'(tmo_err), 64'(1));
    rst = 1; cycle(); rst = 0;
    check("tmo_rst_clear", 64'(tmo_err), 64'(0));

    // Reset while executing with two commands queued.
    fix_clr = 0; fix_resp = 12;
    uq.push_back(16'hE000); uq.push_back(16'hE001); uq.push_back(16'hE002);
    tries = 0;
    while (!(m_phase == 2 && mq.size() == 2) && tries < 40) begin cycle(); tries++; end
    check("mid_setup", 64'(mq.size()), 64'(2));
    rst = 1; cycle(); rst = 0;
    check("mid_reset_outputs", 64'({uart_clr, tour_ack, cmd, cmd_rdy, resp, resp_vld, tmo_err, busy}), 64'(0));
    b_cmd = cmd_log.size(); b_resp = resp_log.size(); b_ack = n_ack;
    repeat (20) cycle();
    check("mid_no_grant", 64'(cmd_log.size() - b_cmd), 64'(0));
    check("mid_no_resp", 64'(resp_log.size() - b_resp), 64'(0));

    // Randomized traffic with spurious handshakes and occasional resets.
    fix_clr = -1; fix_resp = -1; spurious = 1;
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 5) == 0 && uq.size() < 6) uq.push_back(16'($urandom));
      if (tq.size() == 0 && $urandom_range(0, 9) == 0) begin
        cnt = int'($urandom_range(1, 5));
        for (int k = 0; k < cnt; k++) tq.push_back({(k == cnt - 1), 16'($urandom)});
      end
      cycle();
    end
    rst = 0; spurious = 0;
    repeat (5) cycle();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/cmd_sched.md
CMD_SCHED -- requirements
Module: cmd_sched

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning depth of the UART command FIFO (power of 2, >=2).
REQ-002 SHALL have parameter TMO_CYC, default 24'd5_000_000, meaning the maximum clk cycles allowed from command accept to send_resp.
REQ-003 SHALL have parameter FAIR_N, default 4, meaning consecutive tour grants allowed while a UART command waits.
REQ-004 clk  input  1  system clock; one clock; all state on rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 uart_cmd  input  16  command from UART wrapper.
REQ-007 uart_cmd_rdy  input  1  level; uart_cmd valid until uart_clr.
REQ-008 uart_clr  output  1  one-cycle pulse; uart_cmd captured into the FIFO.
REQ-009 tour_cmd  input  16  command from tour sequencer.
REQ-010 tour_vld  input  1  level; held with tour_cmd stable until tour_ack.
REQ-011 tour_last  input  1  qualifies tour_cmd as the final move of the tour.
REQ-012 tour_ack  output  1  one-cycle pulse; tour command consumed by cmd_proc.
REQ-013 cmd  output  16  registered command to cmd_proc.
REQ-014 cmd_rdy  output  1  registered; cmd valid for cmd_proc.
REQ-015 clr_cmd_rdy  input  1  cmd_proc has taken cmd.
REQ-016 send_resp  input  1  cmd_proc has finished the command.
REQ-017 resp  output  8  response byte; valid while resp_vld.
REQ-018 resp_vld  output  1  one-cycle pulse to UART transmitter.
REQ-019 tmo_err  output  1  sticky; command timed out.
REQ-020 busy  output  1  high in any state other than IDLE.

Function
REQ-021 UART FIFO: push when uart_cmd_rdy=1, FIFO not full, and uart_clr was not high the previous cycle; uart_clr asserted in the push cycle only.
REQ-022 FIFO full: uart_cmd_rdy held, no push, no uart_clr, until a slot frees; the entry is never dropped or duplicated.
REQ-023 Push and pop in the same cycle SHALL both occur; count unchanged; pointers wrap modulo DEPTH.
REQ-024 States: IDLE, ISSUE, EXEC, RESP.
REQ-025 IDLE: if tour_vld and (FIFO empty or fair_cnt<FAIR_N), grant tour; else if FIFO not empty, grant UART (pop head); else remain.
REQ-026 On grant: latch cmd and source (and tour_last if tour) and enter ISSUE; cmd_rdy=1 and cmd valid the cycle after the grant.
REQ-027 fair_cnt increments on a tour grant while FIFO is non-empty, clears on a UART grant or when FIFO is empty at arbitration, and saturates at FAIR_N.
REQ-028 ISSUE: hold cmd_rdy=1 and cmd stable; on clr_cmd_rdy go to EXEC, with cmd_rdy=0 from the next cycle; pulse tour_ack in that cycle if the source is tour.
REQ-029 EXEC: watchdog counts from 0 each cycle; on send_resp go to RESP.
REQ-030 Watchdog: if count reaches TMO_CYC-1 without send_resp, set tmo_err and return to IDLE; no resp_vld is issued.
REQ-031 send_resp in the same cycle as the timeout SHALL take priority (go to RESP, tmo_err unchanged).
REQ-032 RESP (one cycle): resp_vld=1; resp=8'hA5 for UART source or tour with latched tour_last=1, else 8'h5A; then IDLE.
REQ-033 send_resp or clr_cmd_rdy outside EXEC/ISSUE respectively SHALL be ignored.
REQ-034 Minimum command turnaround: grant, ISSUE>=1, EXEC>=1, RESP=1; the next grant is evaluated in the IDLE cycle after RESP.
REQ-035 resp holds its last value when resp_vld=0.

Reset
REQ-036 With rst=1 at a clk edge: state=IDLE, FIFO empty, pointers=0, fair_cnt=0, watchdog=0, cmd=16'h0000, cmd_rdy=0, uart_clr=0, tour_ack=0, resp=8'h00, resp_vld=0, tmo_err=0, busy=0.
REQ-037 Reset mid-operation SHALL abort the current command with no tour_ack or resp_vld and discard queued FIFO entries.

Verification
REQ-038 uart_cmd=16'h2002, rdy held; clr_cmd_rdy 2 cycles after cmd_rdy; send_resp 5 cycles later -> one uart_clr, cmd=16'h2002, then resp_vld with resp=8'hA5.
REQ-039 tour_vld with 24 moves, tour_last on the 24th -> 24 tour_acks; 23 responses of 8'h5A, final response 8'h A5.
REQ-040 tour_vld continuous plus 2 queued UART cmds, FAIR_N=4 -> grant order T,T,T,T,U,T,T,T,T,U.
REQ-041 DEPTH=4: 5 UART cmds with cmd_proc stalled -> 4 uart_clr pulses, 5th held until first pop, then captured; all 5 issued in order.
REQ-042 TMO_CYC=16, no send_resp -> tmo_err=1 at cycle 16 of EXEC, back to IDLE; next command proceeds; rst clears tmo_err.
REQ-043 rst asserted in EXEC with 2 queued -> next cycle all outputs at reset values; no stale command issued afterwards.
